clk_gen_param: RTL and testbench

CLK_GEN_PARAM -- requirements
Module: clk_gen_param

---
 rtl/clk_gen_param.sv | 127 ++++++++++++
 tb/tb_clk_gen_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_param.sv
// clk_gen_param: master-counter clock divider with a runtime divide offset applied on counter wrap.
// Optional per-output rising-edge strobes are built when CLK_GEN_STROBE_EN is defined.
module clk_gen_param #(
  parameter int unsigned NUM_OUT = 3
) (
  input  logic               clk8f,
  input  logic               reset,
  input  logic               enable,
  input  logic               cfg_req,
  input  logic [1:0]         cfg_off,
  output logic [NUM_OUT-1:0] clk_out,
  output logic [1:0]         off_cur,
  output logic               cfg_busy,
  output logic               cfg_ack,
  output logic               locked
`ifdef CLK_GEN_STROBE_EN
  ,
  output logic [NUM_OUT-1:0] strb
`endif
);

  localparam int unsigned CNT_W = NUM_OUT + 3;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  if (NUM_OUT == 0 || NUM_OUT > 8) begin : gen_num_out_check
    $error("clk_gen_param: NUM_OUT must be in 1..8");
  end

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:0]         state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         off_q, off_d;
  logic [NUM_OUT-1:0] clk_q, clk_d, clk_nxt;
  logic               ack_q, ack_d;
  logic               locked_q, locked_d;
  logic               wrap, apply;

  assign wrap    = enable && (cnt_q == {CNT_W{1'b1}});
  assign apply   = wrap && (state_q == StPend);
  assign cnt_d   = enable ? cnt_q + CntOne : cnt_q;
  // Outputs follow the next counter value so they are registered yet phase-aligned with cnt.
  assign clk_nxt = NUM_OUT'(cnt_d >> off_q);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    off_d    = off_q;
    locked_d = locked_q;
    ack_d    = 1'b0;
    clk_d    = clk_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_req) begin
          pend_d   = cfg_off;
          state_d  = StPend;
          locked_d = 1'b0;
        end else if (wrap) begin
          locked_d = 1'b1;
        end
      end
      StPend: begin
        if (apply) begin
          off_d    = pend_q;
          ack_d    = 1'b1;
          locked_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // New offset starts from counter value 0 with all outputs low, so no runt pulses.
    if (apply) begin
      clk_d = '0;
    end else if (enable) begin
      clk_d = clk_nxt;
    end
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      state_q  <= StIdle;
      pend_q   <= 2'd0;
      off_q    <= 2'd0;
      clk_q    <= '0;
      ack_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      off_q    <= off_d;
      clk_q    <= clk_d;
      ack_q    <= ack_d;
      locked_q <= locked_d;
    end
  end

  assign clk_out  = clk_q;
  assign off_cur  = off_q;
  assign cfg_busy = (state_q == StPend);
  assign cfg_ack  = ack_q;
  assign locked   = locked_q;

`ifdef CLK_GEN_STROBE_EN
  logic [NUM_OUT-1:0] strb_q, strb_d;

  assign strb_d = (enable && !apply) ? (clk_nxt & ~clk_q) : '0;

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign strb = strb_q;
`endif

endmodule

// File: tb/tb_clk_gen_param.sv
// tb_clk_gen_param: directed self-checking bench for clk_gen_param with NUM_OUT=3 (CNT_W=6).
// Strobe checks are compiled in when CLK_GEN_STROBE_EN is defined.
module tb_clk_gen_param;

  logic       clk8f = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_req;
  logic [1:0] cfg_off;
  logic [2:0] clk_out;
  logic [1:0] off_cur;
  logic       cfg_busy;
  logic       cfg_ack;
  logic       locked;
`ifdef CLK_GEN_STROBE_EN
  logic [2:0] strb;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;  // enabled edges since reset release; expected cnt = cyc % 64

  always #5 clk8f = ~clk8f;

  clk_gen_param #(
    .NUM_OUT (3)
  ) dut (
    .clk8f    (clk8f),
    .reset    (reset),
    .enable   (enable),
    .cfg_req  (cfg_req),
    .cfg_off  (cfg_off),
    .clk_out  (clk_out),
    .off_cur  (off_cur),
    .cfg_busy (cfg_busy),
    .cfg_ack  (cfg_ack),
    .locked   (locked)
`ifdef CLK_GEN_STROBE_EN
    ,
    .strb     (strb)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_clk, input logic [1:0] e_off,
                            input logic e_busy, input logic e_ack, input logic e_lck);
    check_eq({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
    check_eq({tag, ".off_cur"}, 32'(off_cur), 32'(e_off));
    check_eq({tag, ".cfg_busy"}, 32'(cfg_busy), 32'(e_busy));
    check_eq({tag, ".cfg_ack"}, 32'(cfg_ack), 32'(e_ack));
    check_eq({tag, ".locked"}, 32'(locked), 32'(e_lck));
  endtask

  function automatic logic [2:0] exp_clk(input int c, input int off);
    logic [5:0] v;
    v = c[5:0];
    return 3'(v >> off);
  endfunction

  function automatic int cnt_now();
    return cyc % 64;
  endfunction

  task automatic tick();
    @(posedge clk8f);
    #1;
    if (enable && reset) cyc++;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 128 && cnt_now() != target; k++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ack_seen;
    reset   = 1'b1;
    enable  = 1'b0;
    cfg_req = 1'b0;
    cfg_off = 2'd0;
    #1 reset = 1'b0;
    tick();
    tick();
    check_outs("reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef CLK_GEN_STROBE_EN
    check_eq("reset.strb", 32'(strb), 32'd0);
`endif

    // Free run, offset 0: clk_out = cnt[2:0], locked on the 64th edge.
    @(negedge clk8f);
    reset  = 1'b1;
    enable = 1'b1;
    cyc    = 0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      check_eq($sformatf("free.clk_out@%0d", e), 32'(clk_out), 32'(exp_clk(e, 0)));
      check_eq($sformatf("free.locked@%0d", e), 32'(locked), 32'(e == 64));
`ifdef CLK_GEN_STROBE_EN
      check_eq($sformatf("free.strb@%0d", e), 32'(strb),
               32'(exp_clk(e, 0) & ~exp_clk(e - 1, 0)));
`endif
    end
    check_outs("free.end", 3'b000, 2'd0, 1'b0, 1'b0, 1'b1);

    // Offset change to 2 requested at cnt 10.
    run_to(10);
    cfg_req = 1'b1;
    cfg_off = 2'd2;
    tick();
    cfg_req = 1'b0;
    cfg_off = 2'd0;
    check_outs("req", exp_clk(11, 0), 2'd0, 1'b1, 1'b0, 1'b0);

    // Freeze for 5 cycles at cnt 20; a second request while busy must be ignored.
    run_to(20);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        cfg_req = 1'b1;
        cfg_off = 2'd3;
      end
      tick();
      cfg_req = 1'b0;
      check_outs($sformatf("freeze%0d", k), 3'b100, 2'd0, 1'b1, 1'b0, 1'b0);
`ifdef CLK_GEN_STROBE_EN
      check_eq($sformatf("freeze%0d.strb", k), 32'(strb), 32'd0);
`endif
    end
    enable  = 1'b1;
    cfg_req = 1'b1;
    cfg_off = 2'd3;
    tick();
    cfg_req = 1'b0;
    check_outs("busy_req", exp_clk(21, 0), 2'd0, 1'b1, 1'b0, 1'b0);
    run_to(63);
    check_outs("pre_wrap", exp_clk(63, 0), 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("apply", 3'b000, 2'd2, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("post_apply", 3'b000, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tick();
      check_eq($sformatf("off2.clk_out@%0d", cnt_now()), 32'(clk_out),
               32'(exp_clk(cnt_now(), 2)));
    end
    check_eq("off2.off_cur", 32'(off_cur), 32'd2);

    // Reset while a request is pending: cleared at once, never acknowledged.
    cfg_req = 1'b1;
    cfg_off = 2'd1;
    tick();
    cfg_req = 1'b0;
    check_eq("mid.busy", 32'(cfg_busy), 32'd1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check_outs("mid_reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef CLK_GEN_STROBE_EN
    check_eq("mid_reset.strb", 32'(strb), 32'd0);
`endif
    tick();
    tick();
    check_outs("in_reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk8f);
    reset    = 1'b1;
    cyc      = 0;
    ack_seen = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (cfg_ack) ack_seen = 1'b1;
      if (e == 63) check_eq("rerun.locked@63", 32'(locked), 32'd0);
    end
    check_eq("rerun.no_ack", 32'(ack_seen), 32'd0);
    check_outs("rerun.end", 3'b000, 2'd0, 1'b0, 1'b0, 1'b1);

    // Request on the wrap edge is only registered; applied one full counter period later.
    run_to(63);
    cfg_req = 1'b1;
    cfg_off = 2'd1;
    tick();
    cfg_req = 1'b0;
    cfg_off = 2'd0;
    check_outs("wrapreq", 3'b000, 2'd0, 1'b1, 1'b0, 1'b0);
    ack_seen = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      if (cfg_ack) ack_seen = 1'b1;
    end
    check_eq("wrapreq.no_early_ack", 32'(ack_seen), 32'd0);
    check_outs("wrapreq.pre", exp_clk(63, 0), 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("wrapreq.apply", 3'b000, 2'd1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("off1.clk_out@%0d", cnt_now()), 32'(clk_out),
               32'(exp_clk(cnt_now(), 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
